// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine and its change dispenser.
// Holds the change width, coin denominations and the dispenser FSM encoding.
package vending_pkg;

  localparam int unsigned CHG_W    = 5;
  localparam int unsigned TEN_VAL  = 10;
  localparam int unsigned FIVE_VAL = 5;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StEject,
    StGap,
    StFinish,
    StFault
  } state_e;

endpackage

// File: rtl/coin_inventory.sv
// Single coin inventory counter: saturating refill add plus one decrement per cycle.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset, loads INIT
//   refill - add 'added' this cycle
//   added  - number of coins added on refill
//   dec    - one coin ejected this cycle
//   count  - current inventory
module coin_inventory #(
  parameter int unsigned INV_W = 5,
  parameter int unsigned INIT  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refill,
  input  logic [INV_W-1:0] added,
  input  logic             dec,
  output logic [INV_W-1:0] count
);

  localparam logic [INV_W:0] MaxCount = {1'b0, {INV_W{1'b1}}};

  logic [INV_W-1:0] count_q, count_d;
  logic [INV_W:0]   sum;

  // One extra bit holds count + added (+/- 1) without wrapping; dec is only
  // issued when count > 0, so the subtraction never borrows past zero.
  always_comb begin
    sum = {1'b0, count_q};
    if (refill) begin
      sum = sum + {1'b0, added};
    end
    if (dec) begin
      sum = sum - (INV_W+1)'(1);
    end
    count_d = (sum > MaxCount) ? {INV_W{1'b1}} : sum[INV_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= INV_W'(INIT);
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays the change owed by vending_mach as 10 Rs / 5 Rs coins,
// greedy on tens, pacing single-cycle eject pulses by the hopper handshake.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   give, change             - payout request and amount (rupees)
//   hopper_ready             - hopper accepts an eject pulse this cycle
//   refill, ten_added,
//   five_added               - inventory refill strobe and counts
//   eject_ten, eject_five    - one-cycle eject pulses
//   busy, done, fault        - status (fault is sticky until the next give)
//   remaining                - rupees still owed
//   ten_count, five_count    - current inventory
module change_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned CHG_W     = vending_pkg::CHG_W,
  parameter int unsigned INV_W     = 5,
  parameter int unsigned TEN_INIT  = 4,
  parameter int unsigned FIVE_INIT = 4,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             give,
  input  logic [CHG_W-1:0] change,
  input  logic             hopper_ready,
  input  logic             refill,
  input  logic [INV_W-1:0] ten_added,
  input  logic [INV_W-1:0] five_added,
  output logic             eject_ten,
  output logic             eject_five,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [CHG_W-1:0] remaining,
  output logic [INV_W-1:0] ten_count,
  output logic [INV_W-1:0] five_count
);

  localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_e           state_q, state_d;
  logic [CHG_W-1:0] remaining_q, remaining_d;
  logic             sel_ten_q, sel_ten_d;
  logic             fault_q, fault_d;
  logic [GapW-1:0]  gap_q, gap_d;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    sel_ten_d   = sel_ten_q;
    fault_d     = fault_q;
    gap_d       = gap_q;
    eject_ten   = 1'b0;
    eject_five  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (give) begin
          remaining_d = change;
          fault_d     = 1'b0;
          state_d     = StCheck;
        end
      end
      StCheck: begin
        busy = 1'b1;
        if (remaining_q == '0) begin
          state_d = StFinish;
        end else if ((remaining_q % CHG_W'(FIVE_VAL)) != '0) begin
          fault_d = 1'b1;
          state_d = StFault;
        end else if ((remaining_q >= CHG_W'(TEN_VAL)) && (ten_count != '0)) begin
          sel_ten_d = 1'b1;
          state_d   = StEject;
        end else if ((remaining_q >= CHG_W'(FIVE_VAL)) && (five_count != '0)) begin
          sel_ten_d = 1'b0;
          state_d   = StEject;
        end else begin
          fault_d = 1'b1;
          state_d = StFault;
        end
      end
      StEject: begin
        busy = 1'b1;
        if (hopper_ready) begin
          eject_ten   = sel_ten_q;
          eject_five  = ~sel_ten_q;
          remaining_d = remaining_q - (sel_ten_q ? CHG_W'(TEN_VAL) : CHG_W'(FIVE_VAL));
          gap_d       = '0;
          state_d     = StGap;
        end
      end
      StGap: begin
        busy = 1'b1;
        if (gap_q == GapW'(GAP_CYC - 1)) begin
          state_d = StCheck;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      StFault: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      sel_ten_q   <= 1'b0;
      fault_q     <= 1'b0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      sel_ten_q   <= sel_ten_d;
      fault_q     <= fault_d;
      gap_q       <= gap_d;
    end
  end

  assign fault     = fault_q;
  assign remaining = remaining_q;

  coin_inventory #(
    .INV_W (INV_W),
    .INIT  (TEN_INIT)
  ) u_ten_inv (
    .clk    (clk),
    .reset  (reset),
    .refill (refill),
    .added  (ten_added),
    .dec    (eject_ten),
    .count  (ten_count)
  );

  coin_inventory #(
    .INV_W (INV_W),
    .INIT  (FIVE_INIT)
  ) u_five_inv (
    .clk    (clk),
    .reset  (reset),
    .refill (refill),
    .added  (five_added),
    .dec    (eject_five),
    .count  (five_count)
  );

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  localparam int unsigned CHG_W = 5;
  localparam int unsigned INV_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             give;
  logic [CHG_W-1:0] change;
  logic             hopper_ready;
  logic             refill;
  logic [INV_W-1:0] ten_added;
  logic [INV_W-1:0] five_added;
  logic             eject_ten;
  logic             eject_five;
  logic             busy;
  logic             done;
  logic             fault;
  logic [CHG_W-1:0] remaining;
  logic [INV_W-1:0] ten_count;
  logic [INV_W-1:0] five_count;

  int checks   = 0;
  int failures = 0;

  // Expected coin sequence: 1 = ten, 0 = five.
  bit exp_q[$];

  change_dispenser #(
    .CHG_W     (CHG_W),
    .INV_W     (INV_W),
    .TEN_INIT  (4),
    .FIVE_INIT (4),
    .GAP_CYC   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .give         (give),
    .change       (change),
    .hopper_ready (hopper_ready),
    .refill       (refill),
    .ten_added    (ten_added),
    .five_added   (five_added),
    .eject_ten    (eject_ten),
    .eject_five   (eject_five),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .remaining    (remaining),
    .ten_count    (ten_count),
    .five_count   (five_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every eject pulse must match the next expected coin.
  always @(negedge clk) begin
    if (eject_ten || eject_five) begin
      check("single_eject", {31'd0, eject_ten & eject_five}, 32'd0);
      check("eject_expected", exp_q.size(), (exp_q.size() == 0) ? 32'd1 : exp_q.size());
      if (exp_q.size() != 0) begin
        bit e;
        e = exp_q.pop_front();
        check("coin_kind", {31'd0, eject_ten}, {31'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_give(input int c);
    give   = 1'b1;
    change = CHG_W'(c);
    tick();
    give   = 1'b0;
    change = '0;
  endtask

  task automatic wait_end(output bit d, output bit f);
    d = 1'b0;
    f = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) d = 1'b1;
      if (fault) f = 1'b1;
      if (d || f) break;
    end
    check("end_reached", {31'd0, d | f}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit d, f, seen;
    reset = 1'b1; give = 1'b0; change = '0; hopper_ready = 1'b1;
    refill = 1'b0; ten_added = '0; five_added = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_fault", {31'd0, fault}, 0);
    check("rst_remaining", remaining, 0);
    check("rst_ten", ten_count, 4);
    check("rst_five", five_count, 4);

    // 15 -> ten then five, first eject two cycles after give
    tick();
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    start_give(15);
    @(posedge clk);
    @(negedge clk);
    check("latency_eject_ten", {31'd0, eject_ten}, 1);
    wait_end(d, f);
    check("p15_done", {31'd0, d}, 1);
    check("p15_ten", ten_count, 3);
    check("p15_five", five_count, 3);
    check("p15_remaining", remaining, 0);
    check("p15_drained", exp_q.size(), 0);

    // Exhaust tens, then 10 must be paid as two fives
    tick();
    repeat (3) exp_q.push_back(1'b1);
    start_give(30);
    wait_end(d, f);
    check("p30_done", {31'd0, d}, 1);
    check("p30_ten", ten_count, 0);
    tick();
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    start_give(10);
    wait_end(d, f);
    check("p10_done", {31'd0, d}, 1);
    check("p10_five", five_count, 1);
    check("p10_drained", exp_q.size(), 0);

    // Non-multiple of 5 faults; fault is sticky and remaining holds the amount
    tick();
    start_give(7);
    wait_end(d, f);
    check("p7_fault_seen", {31'd0, f}, 1);
    check("p7_no_done", {31'd0, d}, 0);
    tick(); tick();
    @(negedge clk);
    check("p7_fault_sticky", {31'd0, fault}, 1);
    check("p7_remaining", remaining, 7);
    check("p7_busy", {31'd0, busy}, 0);

    // Next give clears fault
    tick();
    exp_q.push_back(1'b0);
    start_give(5);
    @(negedge clk);
    check("fault_cleared", {31'd0, fault}, 0);
    wait_end(d, f);
    check("p5_done", {31'd0, d}, 1);
    check("p5_five", five_count, 0);

    // Refill empty inventory
    tick();
    refill = 1'b1; ten_added = 5'd2; five_added = 5'd3;
    tick();
    refill = 1'b0; ten_added = '0; five_added = '0;
    @(negedge clk);
    check("refill_ten", ten_count, 2);
    check("refill_five", five_count, 3);

    // give while busy is ignored; reset in GAP abandons the payout
    tick();
    exp_q.push_back(1'b1);
    start_give(20);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (eject_ten) begin
        seen = 1'b1;
        break;
      end
    end
    check("gap_first_eject", {31'd0, seen}, 1);
    tick();
    give = 1'b1; change = 5'd20;
    tick();
    give = 1'b0; change = '0; reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_rst_no_eject", {31'd0, eject_ten | eject_five}, 0);
      check("post_rst_busy", {31'd0, busy}, 0);
    end
    check("post_rst_ten", ten_count, 4);
    check("post_rst_five", five_count, 4);
    check("post_rst_drained", exp_q.size(), 0);

    // hopper_ready low: eject waits, busy held
    tick();
    hopper_ready = 1'b0;
    exp_q.push_back(1'b0);
    start_give(5);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stall_busy", {31'd0, busy}, 1);
      check("stall_no_eject", {31'd0, eject_five | eject_ten}, 0);
    end
    tick();
    hopper_ready = 1'b1;
    @(negedge clk);
    check("stall_release_eject", {31'd0, eject_five}, 1);
    wait_end(d, f);
    check("stall_done", {31'd0, d}, 1);
    check("stall_five", five_count, 3);

    // Refill saturation
    tick();
    refill = 1'b1; ten_added = 5'd31;
    tick();
    refill = 1'b0; ten_added = '0;
    @(negedge clk);
    check("sat_ten", ten_count, 31);

    // Refill coinciding with an eject decrement
    tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    hopper_ready = 1'b0;
    exp_q.push_back(1'b1);
    start_give(10);
    tick();
    hopper_ready = 1'b1; refill = 1'b1; ten_added = 5'd2;
    @(negedge clk);
    check("coincide_eject", {31'd0, eject_ten}, 1);
    tick();
    refill = 1'b0; ten_added = '0;
    @(negedge clk);
    check("coincide_ten", ten_count, 5);
    wait_end(d, f);
    check("coincide_done", {31'd0, d}, 1);
    check("coincide_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream stage of vending_mach: consumes its give pulse and change amount and pays change out as physical coins.
- Tracks an inventory of 10 Rs and 5 Rs coins.
- Drives a coin hopper with single-cycle eject pulses, paced by a hopper ready handshake.
- Reports busy, done and fault status back to the front panel.

Parameters:
- CHG_W, 5, width of the change amount in rupees; matches vending_mach change.
- INV_W, 5, width of each coin inventory counter.
- TEN_INIT, 4, number of 10 Rs coins after reset.
- FIVE_INIT, 4, number of 5 Rs coins after reset.
- GAP_CYC, 2, idle cycles forced between consecutive eject pulses (minimum 1).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- give  in  1  vending_mach vend strobe; change is valid in the same cycle.
- change  in  CHG_W  change owed in rupees, sampled when give=1.
- hopper_ready  in  1  hopper can accept an eject pulse this cycle.
- refill  in  1  inventory refill strobe.
- ten_added  in  INV_W  10 Rs coins added on refill.
- five_added  in  INV_W  5 Rs coins added on refill.
- eject_ten  out  1  one-cycle pulse to eject one 10 Rs coin.
- eject_five  out  1  one-cycle pulse to eject one 5 Rs coin.
- busy  out  1  payout in progress.
- done  out  1  one-cycle pulse when payout completes in full.
- fault  out  1  sticky; payout impossible. Cleared by the next accepted give or by reset.
- remaining  out  CHG_W  rupees still owed.
- ten_count  out  INV_W  current 10 Rs inventory.
- five_count  out  INV_W  current 5 Rs inventory.

Behaviour:
- Reset: all state is synchronous to clk.
  - eject_ten, eject_five, busy, done, fault = 0; remaining = 0.
  - ten_count = TEN_INIT; five_count = FIVE_INIT; FSM goes to IDLE.
  - Reset mid-payout abandons the payout with no further ejects.
- FSM states: IDLE, CHECK, EJECT, GAP, FINISH, FAULT.
- IDLE:
  - On give=1: latch remaining=change, clear fault, go to CHECK.
  - give is ignored in every other state; no queueing.
- CHECK (busy=1):
  - remaining==0 -> FINISH.
  - remaining not a multiple of 5 -> FAULT.
  - remaining>=10 and ten_count>0 -> EJECT with ten selected.
  - else remaining>=5 and five_count>0 -> EJECT with five selected.
  - otherwise -> FAULT.
  - Greedy rule: a 10 is used whenever one is available. Two 5s substitute for a missing 10.
- EJECT (busy=1):
  - Wait while hopper_ready=0.
  - In the first cycle with hopper_ready=1, assert exactly one of eject_ten or eject_five.
  - In that same cycle, decrement the selected counter and reduce remaining by 10 or 5.
  - Then go to GAP.
- GAP (busy=1): hold for GAP_CYC cycles, then go to CHECK. Ejects are therefore spaced at least GAP_CYC+2 cycles apart.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- FAULT:
  - fault=1, busy=0; remaining holds the unpaid amount.
  - Go to IDLE next cycle; fault stays sticky.
- Refill:
  - Accepted in any state.
  - Each counter becomes min(count + added, 2^INV_W-1), saturating.
  - If refill coincides with an eject decrement, the result is count + added - 1, saturated.
  - A refill during EJECT takes effect in the next CHECK.
- Counters never wrap below 0; CHECK guarantees count>0 before any eject.
- Latency: give to first eject is 2 cycles when hopper_ready=1. give with change=0 gives done 2 cycles later.

Decomposition:
- Shared package vending_pkg holds:
  - FSM state encoding constants.
  - Coin values TEN_VAL=10 and FIVE_VAL=5.
  - CHG_W, reused by vending_mach.
- One natural sub-module, coin_inventory: a single saturating counter with a refill add and a single decrement. It is instantiated twice (ten and five).

Test Plan:
- Reset, then give with change=15, hopper_ready=1 -> eject_ten once, then eject_five once. done pulses; ten_count=3, five_count=3, remaining=0.
- ten_count exhausted via refill-free payouts, then give with change=10 -> two eject_five pulses, no eject_ten, done asserted.
- give with change=7 -> no ejects; fault=1, remaining=7, done never asserted. The next give with change=5 clears fault.
- hopper_ready held 0 for 5 cycles during payout of change=5 -> eject_five asserted only in the first cycle hopper_ready returns 1. busy stays 1 throughout.
- give with change=20 while busy, and reset asserted during GAP -> the second give is ignored. After reset: counts=TEN_INIT/FIVE_INIT, busy=0, no further ejects.
- refill with ten_added=31 and ten_count=4 -> ten_count saturates at 31. refill coinciding with eject_ten from ten_count=4, ten_added=2 -> ten_count=5.
